// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch path: reset address,
// word widths, buffer entry layout and fetch state encodings.
package inst_fetch_pkg;

    localparam int          INST_W       = 32;
    localparam int          ENTRY_W      = 2 * INST_W;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    // Targets are always word aligned; the low two bits are dropped silently.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// Small synchronous FIFO holding {pc, inst} pairs between the ROM and decode.
// Clear wins over push; push while full is accepted only alongside a pop.
module fetch_buf
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               clear_i,
    input  logic [ENTRY_W-1:0] din_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [ENTRY_W-1:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = push_i && (!w_full || pop_i) && !clear_i;
    assign w_do_pop  = pop_i && !w_empty && !clear_i;

    assign full_o  = w_full;
    assign empty_o = w_empty;
    // An empty buffer presents zeros rather than stale data.
    assign head_o  = w_empty ? {ZERO_WORD, ZERO_WORD} : r_mem[r_rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage write; contents are qualified by the count, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: owns the PC, issues ROM requests when the
// output buffer has room, and steers the PC on flush/branch redirects.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_pc,
    output logic        rom_ce,
    input  logic [31:0] rom_inst,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        id_ready_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;

    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head;
    logic               w_pop;
    logic               w_redirect;
    logic               w_fetch;

    assign w_pop      = !w_empty && id_ready_i;
    assign w_redirect = flush_i || branch_flag_i;
    // A slot frees up this cycle if decode is taking the head.
    assign w_fetch    = (r_state == FETCH) && (!w_full || w_pop) && !w_redirect;

    assign rom_ce     = w_fetch;
    assign rom_pc     = r_pc;
    assign id_valid_o = !w_empty;
    assign id_pc_o    = w_head[ENTRY_W-1:INST_W];
    assign id_inst_o  = w_head[INST_W-1:0];

    // State and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Next state and PC selection: flush beats branch beats sequential.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        if (r_state == IDLE) begin
            w_state_next = FETCH;
        end
        if (flush_i) begin
            w_pc_next = align_word(new_pc_i);
        end else if (branch_flag_i) begin
            w_pc_next = align_word(branch_target_i);
        end else if (w_fetch) begin
            w_pc_next = r_pc + 32'd4;
        end
    end

    fetch_buf #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_fetch),
        .pop_i   (w_pop),
        .clear_i (w_redirect),
        .din_i   ({r_pc, rom_inst}),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch initiator for the Jahangir core: drives the instruction ROM's `pc`/`ce` request and captures the returned 32-bit word. It delivers (pc, instruction) pairs to decode through a 2-entry buffer with a valid/ready handshake. It handles downstream stalls, branch redirects and pipeline flushes. It sits between the ROM and the IF/ID boundary and replaces a bare PC register.

## Interface

- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `BUF_DEPTH`, 2, output buffer entries; only 2 is supported.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `rom_pc` out 32: byte address to ROM.
- `rom_ce` out 1: ROM enable, 1 = fetch this cycle.
- `rom_inst` in 32: ROM data, combinational from `rom_pc`/`rom_ce` within the same cycle.
- `branch_flag_i` in 1: redirect request from decode.
- `branch_target_i` in 32: redirect address.
- `flush_i` in 1: exception or flush request.
- `new_pc_i` in 32: flush target address.
- `id_ready_i` in 1: decode accepts the head entry this cycle.
- `id_valid_o` out 1: the head entry is valid.
- `id_pc_o` out 32: PC of the head entry.
- `id_inst_o` out 32: instruction of the head entry.

## Operation

- **States:**
  - IDLE: entered on reset; `rom_ce`=0.
  - FETCH: normal fetching.
  - IDLE→FETCH unconditionally at the first edge after `rst` falls.
  - FETCH stays FETCH; only `rst` returns the block to IDLE.
- **Fetch condition:** `rom_ce` = (state==FETCH) && (!full || pop) && !flush_i && !branch_flag_i. It is combinational.
  - `rom_pc` = `pc` register, always driven, including when `rom_ce`=0.
- **Push:** when `rom_ce`=1, the edge writes {`pc`, `rom_inst`} into the buffer tail and sets `pc` <= `pc`+4.
  - Arithmetic is 32-bit modulo; 0xFFFF_FFFC wraps to 0x0000_0000.
- **Pop:** pop = `id_valid_o` && `id_ready_i`; the head is removed at the edge.
  - Push and pop in the same cycle are allowed, including when the buffer is full.
- **Redirect priority:** `flush_i` > `branch_flag_i` > sequential.
  - On flush, `pc` <= {`new_pc_i`[31:2], 2'b00}.
  - On branch, `pc` <= {`branch_target_i`[31:2], 2'b00}.
  - In both cases the buffer is cleared at that edge and no push occurs.
  - A pop in the same cycle still counts as accepted by decode.
- **Low address bits:** the low 2 bits of any target are forced to 0; misalignment is not reported.
- **Empty buffer:** `id_valid_o`=0, and `id_pc_o` and `id_inst_o` read 32'h0.

## Timing

- **Reset values (asynchronous):**
  - State IDLE, `pc`=`RESET_PC`, buffer empty.
  - `rom_ce`=0, `rom_pc`=`RESET_PC`.
  - `id_valid_o`=0, `id_pc_o`=0, `id_inst_o`=0.
- **Startup:** cycle 0 is the first cycle after `rst` falls (IDLE). Cycle 1 has `rom_ce`=1 at `RESET_PC`. Cycle 2 has `id_valid_o`=1.
- **Latency:** 1 cycle from a fetch to its appearance at the head when the buffer is empty.
- **Throughput:** 1 instruction per cycle while `id_ready_i`=1.
- **Stall:** with `id_ready_i`=0, at most 2 further fetches land and `rom_ce` then drops to 0. Outputs hold stable while `id_valid_o`=1 and `id_ready_i`=0.
- **Redirect:** the first target fetch happens in the cycle after `branch_flag_i`/`flush_i` is sampled. The target appears at `id_*` two cycles after the request, with no wrong-path entry visible in between.
- **Reset mid-operation:** asserting `rst` immediately clears the buffer and forces the reset values regardless of the clock.

## Structure

- **Shared defines header:** `RESET_PC` default, instruction width (32), `ZERO_WORD` (32'h0), and state encodings IDLE/FETCH. These are also used by the ROM and `pc_reg` users.
- **Sub-module `fetch_buf`:** 2-entry, 64-bit-wide synchronous FIFO.
  - Inputs: push, pop, clear (synchronous, higher priority than push).
  - Outputs: full, empty, head.
  - Uses `clk`/`rst` with the same asynchronous reset.
- **`inst_fetch`:** holds the `pc` register, the state register, the fetch-condition logic and the redirect muxing.

## Test plan

- **Reset and start:** hold `rst` 3 cycles, release, `id_ready_i`=1, ROM word = address. Expect `rom_ce` 0,1,1…; `id_pc_o` 0x0,0x4,0x8 on consecutive cycles from cycle 2; `id_inst_o`=`id_pc_o`.
- **Stall:** drop `id_ready_i` for 5 cycles mid-stream with head 0x10. Expect exactly two buffered entries (0x10, 0x14), `rom_ce`=0 after that, and `id_*` stable. On release, 0x10, 0x14, 0x18 stream with no gaps and no duplicates.
- **Branch:** assert `branch_flag_i` with target 0x103 while head 0x20 is popped. Expect the next valid `id_pc_o`=0x100 two cycles later, no 0x24/0x28 ever valid, and `rom_pc`=0x100 in the following cycle.
- **Flush vs branch:** assert `flush_i` (0x400) and `branch_flag_i` (0x100) together. Expect a redirect to 0x400 only.
- **Wrap:** `RESET_PC`=0xFFFF_FFF8. Expect `id_pc_o` 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Async reset mid-stream:** pulse `rst` between clock edges with the buffer full. Expect `id_valid_o`=0 and `rom_ce`=0 immediately, and a restart from `RESET_PC`.
